// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MIPS fetch-address generator with redirect buffering
// and a BOOT/RUN/HALTED single-step FSM.
// Ports:
//   clk, reset        clock, async active-high reset
//   stall, imem_ready hold conditions for the PC
//   branch_taken/imm  conditional branch redirect (word offset)
//   jump/jump_index   J-type redirect
//   jr/jr_target      jump-register redirect
//   halt, resume      single-step control
//   pc, pc_plus4      fetch address and its successor
//   pc_valid, halted  registered FSM status
//   fetch_count       accepted-fetch counter (wraps)
module pc_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          COUNT_W      = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               imem_ready,
   input  logic               branch_taken,
   input  logic [15:0]        branch_imm,
   input  logic               jump,
   input  logic [25:0]        jump_index,
   input  logic               jr,
   input  logic [31:0]        jr_target,
   input  logic               halt,
   input  logic               resume,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4,
   output logic               pc_valid,
   output logic               halted,
   output logic [COUNT_W-1:0] fetch_count
);

   localparam logic [1:0] BOOT   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic        pending_valid;
   logic [31:0] pending_target;
   logic        accept;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] next_pc;

   assign pc_plus4 = pc + 32'd4;
   assign accept   = pc_valid & imem_ready & ~stall;
   assign redirect = jr | jump | branch_taken;

   // Redirect sources may overlap; jr outranks jump outranks branch.
   always_comb begin
      target = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
      if (jr)
         target = {jr_target[31:2], 2'b00};
      else if (jump)
         target = {pc_plus4[31:28], jump_index, 2'b00};
   end

   always_comb begin
      next_pc = pc_plus4;
      if (redirect)
         next_pc = target;
      else if (pending_valid)
         next_pc = pending_target;
   end

   // halt has priority over resume in both RUN and HALTED.
   always_comb begin
      state_nxt = state;
      unique case (state)
         BOOT:    state_nxt = RUN;
         RUN:     if (halt) state_nxt = HALTED;
         HALTED:  if (resume && !halt) state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= BOOT;
         pc_valid <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc_valid <= (state_nxt == RUN);
         halted   <= (state_nxt == HALTED);
      end
   end

   // A redirect that cannot be taken now is parked until the next
   // accept; a newer one replaces it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc             <= RESET_VECTOR;
         fetch_count    <= '0;
         pending_valid  <= 1'b0;
         pending_target <= 32'h0;
      end else if (accept) begin
         pc            <= next_pc;
         fetch_count   <= fetch_count + {{(COUNT_W-1){1'b0}}, 1'b1};
         pending_valid <= 1'b0;
      end else if (redirect) begin
         pending_valid  <= 1'b1;
         pending_target <= target;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and random checks of pc_fetch_unit
// against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        imem_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_imm = '0;
   logic        jump = 1'b0;
   logic [25:0] jump_index = '0;
   logic        jr = 1'b0;
   logic [31:0] jr_target = '0;
   logic        halt = 1'b0;
   logic        resume = 1'b0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        pc_valid;
   logic        halted;
   logic [31:0] fetch_count;

   int total = 0;
   int bad   = 0;

   // model: mode 0=boot 1=run 2=halted; pend holds at most one target
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   logic [31:0] pend[$];

   pc_fetch_unit #(.RESET_VECTOR(32'h0), .COUNT_W(32)) dut (
      .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
      .branch_taken(branch_taken), .branch_imm(branch_imm),
      .jump(jump), .jump_index(jump_index), .jr(jr),
      .jr_target(jr_target), .halt(halt), .resume(resume),
      .pc(pc), .pc_plus4(pc_plus4), .pc_valid(pc_valid),
      .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"}, pc, m_pc);
      chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
      chk({tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, m_mode == 1});
      chk({tag, ".halted"}, {31'b0, halted}, {31'b0, m_mode == 2});
      chk({tag, ".count"}, fetch_count, m_cnt);
   endtask

   task automatic clear_in();
      stall = 0; imem_ready = 0; branch_taken = 0; branch_imm = 0;
      jump = 0; jump_index = 0; jr = 0; jr_target = 0;
      halt = 0; resume = 0;
   endtask

   // Advance one clock: predict from the inputs now applied, then check.
   task automatic step(input string tag);
      logic [31:0] p4, t;
      int sx;
      bit acc, redir;
      p4    = m_pc + 32'd4;
      acc   = (m_mode == 1) && imem_ready && !stall;
      redir = jr || jump || branch_taken;
      sx    = int'($signed(branch_imm));
      if (jr)        t = jr_target & 32'hFFFF_FFFC;
      else if (jump) t = (p4 & 32'hF000_0000) | ({6'b0, jump_index} * 4);
      else           t = p4 + 32'(sx * 4);
      if (acc) begin
         if (redir)              m_pc = t;
         else if (pend.size())   m_pc = pend[0];
         else                    m_pc = p4;
         pend.delete();
         m_cnt++;
      end else if (redir) begin
         pend.delete();
         pend.push_back(t);
      end
      case (m_mode)
         0: m_mode = 1;
         1: if (halt) m_mode = 2;
         2: if (resume && !halt) m_mode = 1;
         default: m_mode = 0;
      endcase
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // Reset asserted between edges must act at once.
   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1;
      m_mode = 0; m_pc = 32'h0; m_cnt = 0; pend.delete();
      #1;
      check_all(tag);
      @(negedge clk);
      reset = 0;
   endtask

   task automatic go_jr(input logic [31:0] a);
      clear_in(); imem_ready = 1; jr = 1; jr_target = a;
      step("setjr");
      clear_in();
   endtask

   initial begin
      m_mode = 0; m_pc = 0; m_cnt = 0;
      do_reset("reset");

      // boot then four sequential fetches
      clear_in(); imem_ready = 1;
      step("boot");
      for (int i = 0; i < 4; i++) step("seq");
      chk("seq.count4", fetch_count, 32'd4);

      // branch backwards from 0x100
      go_jr(32'h100);
      imem_ready = 1; branch_taken = 1; branch_imm = 16'hFFFE;
      step("branch");
      chk("branch.pc", pc, 32'h0FC);

      // jump keeps upper nibble of pc+4
      go_jr(32'h1000_0000);
      imem_ready = 1; jump = 1; jump_index = 26'h40;
      step("jump");
      chk("jump.pc", pc, 32'h1000_0100);

      // all three at once: jr wins
      clear_in(); imem_ready = 1; jr = 1; jr_target = 32'h3003;
      jump = 1; jump_index = 26'h1234; branch_taken = 1; branch_imm = 16'h7;
      step("prio");
      chk("prio.pc", pc, 32'h3000);

      // redirect parked while imem not ready
      clear_in(); jr = 1; jr_target = 32'h200;
      step("hold0");
      clear_in();
      step("hold1");
      step("hold2");
      chk("hold.pc", pc, 32'h3000);
      imem_ready = 1;
      step("release");
      chk("release.pc", pc, 32'h200);
      step("after");
      chk("pend_cleared", pc, 32'h204);

      // sequential wrap
      go_jr(32'hFFFF_FFFC);
      imem_ready = 1;
      step("wrap");
      chk("wrap.pc", pc, 32'h0);

      // halt with accept at 0x20
      go_jr(32'h20);
      imem_ready = 1; halt = 1;
      step("halt");
      chk("halt.pc", pc, 32'h24);
      chk("halt.flag", {31'b0, halted}, 32'd1);
      halt = 1; resume = 1;
      step("halt_resume");
      chk("halt_wins", {31'b0, halted}, 32'd1);
      halt = 0; resume = 1;
      step("resume");
      resume = 0;
      step("resume_fetch");
      chk("resume.pc", pc, 32'h28);

      // pending redirect discarded by async reset
      clear_in(); jr = 1; jr_target = 32'h500;
      step("pend_before_reset");
      clear_in(); imem_ready = 1;
      do_reset("mid_reset");
      step("reboot");
      step("reboot_fetch");
      chk("reboot.pc", pc, 32'h4);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         imem_ready   = ($urandom_range(0, 3) != 0);
         stall        = ($urandom_range(0, 4) == 0);
         jr           = ($urandom_range(0, 19) == 0);
         jr_target    = $urandom;
         jump         = ($urandom_range(0, 19) == 0);
         jump_index   = 26'($urandom);
         branch_taken = ($urandom_range(0, 9) == 0);
         branch_imm   = 16'($urandom);
         halt         = ($urandom_range(0, 29) == 0);
         resume       = ($urandom_range(0, 4) == 0);
         step("rand");
         if (i == 300) do_reset("rand_reset");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
